gray_ptr_sync: RTL and testbench

- Multi-channel receive-side synchroniser for Gray-coded counters/pointers generated in foreign clock domains.
- Per channel, all in the single destination clock domain:
  - parametrisable-depth synchroniser chain
  - Gray-to-binary conversion
  - single-step legality check
  - per-sample increment (delta) output
- Used by the async FIFO and rate-monitor blocks as the read-side pointer/counter front end.

---
 rtl/gray_sync_pkg.sv | 37 +++
 rtl/gray_sync_chan.sv | 98 +++++++++
 rtl/gray_ptr_sync.sv | 65 ++++++
 tb/tb_gray_ptr_sync.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_sync_pkg.sv
// Shared helpers for the Gray-pointer receive synchroniser: Gray/binary conversion,
// bit counting and warm-up counter sizing. Helpers operate on up to MAX_W bits.
package gray_sync_pkg;

  localparam int unsigned MAX_W            = 32;
  localparam int unsigned SYNC_STAGES_DFLT = 2;

  function automatic int unsigned warm_w(input int unsigned stages);
    return $clog2(stages + 2);
  endfunction

  localparam int unsigned WARM_W = $clog2(SYNC_STAGES_DFLT + 2);

  // Narrower counters are zero-extended by the caller, so upper bits add nothing.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = g;
    for (int i = 1; i < MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_sync_chan.sv
// One channel: synchroniser chain, previous-sample register, Hamming-distance check
// and the binary/delta/changed/error outputs.
module gray_sync_chan
  import gray_sync_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             warm_i,
  input  logic [WIDTH-1:0] gray_i,
  input  logic             err_clr_i,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] delta_o,
  output logic             changed_o,
  output logic             err_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] g_sync;
  logic [WIDTH-1:0] g_prev_q, g_prev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             chg_q, chg_d;
  logic             err_q, err_d;
  logic             err_set;
  logic [WIDTH-1:0] bin_new;
  int unsigned      hd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign g_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    bin_new  = WIDTH'(gray2bin(MAX_W'(g_sync)));
    hd       = popcount(MAX_W'(g_sync ^ g_prev_q));
    g_prev_d = g_prev_q;
    bin_d    = bin_q;
    delta_d  = delta_q;
    chg_d    = 1'b0;
    err_set  = 1'b0;
    if (warm_i) begin
      g_prev_d = g_sync;
      bin_d    = bin_new;
      delta_d  = '0;
    end else if (hd == 1) begin
      g_prev_d = g_sync;
      bin_d    = bin_new;
      delta_d  = bin_new - bin_q;
      chg_d    = 1'b1;
    end else if (hd >= 2) begin
      err_set  = 1'b1;
      // g_prev always re-bases so the next legal step is judged against the new sample.
      g_prev_d = g_sync;
      if (HOLD_ON_ERR == 0) begin
        bin_d   = bin_new;
        delta_d = bin_new - bin_q;
        chg_d   = 1'b1;
      end
    end
    err_d = err_set | (err_q & ~err_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_prev_q <= '0;
      bin_q    <= '0;
      delta_q  <= '0;
      chg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      g_prev_q <= g_prev_d;
      bin_q    <= bin_d;
      delta_q  <= delta_d;
      chg_q    <= chg_d;
      err_q    <= err_d;
    end
  end

  assign bin_o     = bin_q;
  assign delta_o   = delta_q;
  assign changed_o = chg_q;
  assign err_o     = err_q;

endmodule

// File: rtl/gray_ptr_sync.sv
// Multi-channel receive-side Gray pointer synchroniser: one shared warm-up counter
// and NCH independent channels.
module gray_ptr_sync
  import gray_sync_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned NCH         = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_ON_ERR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] i_gray,
  input  logic [NCH-1:0]       i_err_clr,
  output logic [NCH*WIDTH-1:0] o_bin,
  output logic [NCH*WIDTH-1:0] o_delta,
  output logic [NCH-1:0]       o_changed,
  output logic [NCH-1:0]       o_err,
  output logic                 o_valid
);

  localparam int unsigned CNT_W = warm_w(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SYNC_STAGES);

  logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic             valid_q, valid_d;

  // The chain needs SYNC_STAGES edges to fill and one more to load g_prev/o_bin.
  always_comb begin
    warm_cnt_d = (warm_cnt_q == CNT_LAST) ? warm_cnt_q : warm_cnt_q + 1'b1;
    valid_d    = valid_q | (warm_cnt_q == CNT_PRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      warm_cnt_q <= warm_cnt_d;
      valid_q    <= valid_d;
    end
  end

  assign o_valid = valid_q;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    gray_sync_chan #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .HOLD_ON_ERR (HOLD_ON_ERR)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .warm_i    (~valid_q),
      .gray_i    (i_gray[c*WIDTH +: WIDTH]),
      .err_clr_i (i_err_clr[c]),
      .bin_o     (o_bin[c*WIDTH +: WIDTH]),
      .delta_o   (o_delta[c*WIDTH +: WIDTH]),
      .changed_o (o_changed[c]),
      .err_o     (o_err[c])
    );
  end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Scoreboard bench for gray_ptr_sync: two instances (accept / hold on illegal samples)
// share stimulus; a reference model predicts every o_changed event and the sticky errors.
module tb_gray_ptr_sync;

  localparam int W = 4;
  localparam int N = 2;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] i_gray = '0;
  logic [N-1:0]   i_err_clr = '0;

  logic [N*W-1:0] o_bin0, o_delta0, o_bin1, o_delta1;
  logic [N-1:0]   o_changed0, o_err0, o_changed1, o_err1;
  logic           o_valid0, o_valid1;

  gray_ptr_sync #(.WIDTH(W), .NCH(N), .SYNC_STAGES(S), .HOLD_ON_ERR(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_gray(i_gray), .i_err_clr(i_err_clr),
    .o_bin(o_bin0), .o_delta(o_delta0), .o_changed(o_changed0), .o_err(o_err0),
    .o_valid(o_valid0));

  gray_ptr_sync #(.WIDTH(W), .NCH(N), .SYNC_STAGES(S), .HOLD_ON_ERR(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_gray(i_gray), .i_err_clr(i_err_clr),
    .o_bin(o_bin1), .o_delta(o_delta1), .o_changed(o_changed1), .o_err(o_err1),
    .o_valid(o_valid1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       d;
    int       c;
    logic [3:0] bin;
    logic [3:0] delta;
    int       due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  logic [3:0] m_prev [N];
  logic [3:0] m_bin  [2][N];
  bit         m_err  [2][N];

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    bit acc;
    acc = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  function automatic logic [3:0] b2g(input int n);
    logic [3:0] v;
    v = n[3:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int hdist(input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (a[i] != b[i]) n++;
    return n;
  endfunction

  function automatic logic [3:0] dbin(input int d, input int c);
    return (d == 0) ? o_bin0[c*W +: W] : o_bin1[c*W +: W];
  endfunction
  function automatic logic [3:0] ddelta(input int d, input int c);
    return (d == 0) ? o_delta0[c*W +: W] : o_delta1[c*W +: W];
  endfunction
  function automatic logic dchg(input int d, input int c);
    return (d == 0) ? o_changed0[c] : o_changed1[c];
  endfunction
  function automatic logic derr(input int d, input int c);
    return (d == 0) ? o_err0[c] : o_err1[c];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: every o_changed pulse must match the oldest pending prediction for that
  // instance/channel, including the cycle it was due.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < N; c++) begin
          if (dchg(d, c)) begin
            int idx;
            idx = -1;
            for (int k = 0; k < sb.size(); k++) begin
              if (idx < 0 && sb[k].d == d && sb[k].c == c) idx = k;
            end
            if (idx < 0) begin
              check($sformatf("spurious_chg_d%0d_c%0d", d, c), 32'(dchg(d, c)), 32'd0);
            end else begin
              check($sformatf("chg_bin_d%0d_c%0d", d, c), 32'(dbin(d, c)), 32'(sb[idx].bin));
              check($sformatf("chg_delta_d%0d_c%0d", d, c), 32'(ddelta(d, c)), 32'(sb[idx].delta));
              check($sformatf("chg_cycle_d%0d_c%0d", d, c), 32'(cyc), 32'(sb[idx].due));
              sb.delete(idx);
            end
          end
        end
      end
    end
  end

  // Called at a negedge; drives one new input sample and leaves it stable for 4 cycles.
  // coinc puts the clear on the same edge that the new sample reaches the compare stage.
  task automatic apply(input logic [3:0] g0, input logic [3:0] g1,
                       input logic [1:0] clr, input bit coinc);
    logic [3:0] g [N];
    bit         ill [N];
    g[0] = g0;
    g[1] = g1;
    i_gray = {g1, g0};
    for (int c = 0; c < N; c++) begin
      int hd;
      hd = hdist(g[c], m_prev[c]);
      ill[c] = (hd >= 2);
      if (hd != 0) begin
        for (int d = 0; d < 2; d++) begin
          if (hd == 1 || d == 0) begin
            logic [3:0] nb, dl;
            nb = g2b(g[c]);
            dl = nb - m_bin[d][c];
            sb.push_back('{d, c, nb, dl, cyc + S + 1});
            m_bin[d][c] = nb;
          end
        end
      end
      m_prev[c] = g[c];
    end
    if (coinc) begin
      repeat (2) @(negedge clk);
      i_err_clr = clr;
      @(negedge clk);
      i_err_clr = '0;
      @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
      i_err_clr = clr;
      @(negedge clk);
      i_err_clr = '0;
    end
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N; c++) begin
        if (coinc) m_err[d][c] = ill[c] ? 1'b1 : (clr[c] ? 1'b0 : m_err[d][c]);
        else       m_err[d][c] = clr[c] ? 1'b0 : (m_err[d][c] | ill[c]);
        check($sformatf("step_bin_d%0d_c%0d", d, c), 32'(dbin(d, c)), 32'(m_bin[d][c]));
        check($sformatf("step_err_d%0d_c%0d", d, c), 32'(derr(d, c)), 32'(m_err[d][c]));
      end
    end
  endtask

  // Called right after reset release at a negedge, with the input already stable.
  task automatic warm_check();
    logic [7:0] eb;
    eb = {g2b(m_prev[1]), g2b(m_prev[0])};
    @(negedge clk);
    check("valid_edge1", 32'({o_valid1, o_valid0}), 32'd0);
    @(negedge clk);
    check("valid_edge2", 32'({o_valid1, o_valid0}), 32'd0);
    @(negedge clk);
    check("valid_edge3", 32'({o_valid1, o_valid0}), 32'd3);
    check("warm_bin_d0", 32'(o_bin0), 32'(eb));
    check("warm_bin_d1", 32'(o_bin1), 32'(eb));
    check("warm_err", 32'({o_err1, o_err0}), 32'd0);
    check("warm_delta", 32'({o_delta1, o_delta0}), 32'd0);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N; c++) begin
        m_bin[d][c] = g2b(m_prev[c]);
        m_err[d][c] = 1'b0;
      end
    end
  endtask

  task automatic rand_step();
    logic [3:0] ng [N];
    logic [1:0] clr;
    for (int c = 0; c < N; c++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 4)      ng[c] = b2g(int'(g2b(m_prev[c])) + 1);
      else if (r <= 6) ng[c] = b2g(int'(g2b(m_prev[c])) + 15);
      else if (r == 7) ng[c] = m_prev[c];
      else             ng[c] = 4'($urandom_range(0, 15));
    end
    clr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
    apply(ng[0], ng[1], clr, bit'($urandom_range(0, 1)));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    i_gray = 8'h66;
    repeat (3) @(negedge clk);
    check("in_reset_d0", 32'({o_bin0, o_delta0, o_changed0, o_err0, o_valid0}), 32'd0);
    check("in_reset_d1", 32'({o_bin1, o_delta1, o_changed1, o_err1, o_valid1}), 32'd0);
    m_prev[0] = 4'b0110;
    m_prev[1] = 4'b0110;
    rst_n = 1'b1;
    warm_check();
    check("warm_bin_is_4", 32'(o_bin0[3:0]), 32'd4);

    // Count-up sweep 5..20 covers the 15 -> 0 wrap.
    for (int n = 5; n <= 20; n++) apply(b2g(n), b2g(n), 2'b00, 1'b0);
    // Count-down through 2 -> 1 and on to 0.
    for (int n = 3; n >= 0; n--) begin
      apply(b2g(n), b2g(n), 2'b00, 1'b0);
      if (n == 1) check("decrement_delta", 32'(ddelta(0, 0)), 32'hF);
    end

    // ch0 illegal 0000 -> 0011, ch1 legal 0000 -> 0001.
    apply(4'b0011, 4'b0001, 2'b00, 1'b0);
    check("illegal_bin_acc", 32'(dbin(0, 0)), 32'd2);
    check("illegal_delta_acc", 32'(ddelta(0, 0)), 32'd2);
    check("illegal_bin_hold", 32'(dbin(1, 0)), 32'd0);
    check("illegal_err_iso", 32'({o_err1, o_err0}), 32'b0101);
    check("iso_ch1_bin", 32'(dbin(0, 1)), 32'd1);
    apply(4'b0010, 4'b0011, 2'b00, 1'b0);
    check("rebase_bin_hold", 32'(dbin(1, 0)), 32'd3);
    check("rebase_delta_hold", 32'(ddelta(1, 0)), 32'd3);

    repeat (20) @(negedge clk);
    check("sticky_err", 32'({o_err1[0], o_err0[0]}), 32'd3);
    apply(4'b0010, 4'b0011, 2'b01, 1'b0);
    check("clr_err", 32'({o_err1[0], o_err0[0]}), 32'd0);
    apply(4'b0111, 4'b0011, 2'b01, 1'b1);
    check("clr_vs_set", 32'({o_err1[0], o_err0[0]}), 32'd3);

    for (int i = 0; i < 60; i++) rand_step();

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_d0", 32'({o_bin0, o_delta0, o_changed0, o_err0, o_valid0}), 32'd0);
    check("async_rst_d1", 32'({o_bin1, o_delta1, o_changed1, o_err1, o_valid1}), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    warm_check();

    for (int i = 0; i < 20; i++) rand_step();
    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
